// File: rtl/oled_i2c_sequencer.sv
// Byte-level I2C master: frames START / 8 data bits / ACK slot / STOP from valid-ready byte commands.
// Latency: an IDLE command with START drops SDA HALF_PERIOD clocks after acceptance; a byte takes 2*HALF_PERIOD per bit.
// Backpressure: cmd_ready is high only in IDLE or HOLD, so a new byte waits until the current frame completes.
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_start/cmd_stop/cmd_data (upstream byte command);
//        sda_in (pad level for ACK); scl/sda_out/sda_oe (pad controls); done (completion pulse), busy, ack_err (sticky NACK).
// Optional: define OLED_I2C_ACK_CHECK_EN to act on NACK (set ack_err and force STOP); otherwise sda_in is ignored.
module oled_i2c_sequencer #(
  parameter int HALF_PERIOD = 350,
  parameter int SDA_SETUP   = HALF_PERIOD / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic [7:0] cmd_data,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_out,
  output logic       sda_oe,
  output logic       done,
  output logic       busy,
  output logic       ack_err
);

  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] CNT_LAST   = CW'(HALF_PERIOD - 1);
  // Registered SDA changes are decided one count early so they are visible from count SDA_SETUP.
  localparam logic [CW-1:0] CNT_SETUP  = CW'(SDA_SETUP - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(HALF_PERIOD / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RSTART, S_START, S_BIT, S_ACK, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sub_q, sub_d;      // half-period slot inside the current state
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          stop_q, stop_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          oe_q, oe_d;
  logic          done_q, done_d;
  logic          accept, wrap, at_setup;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign wrap      = (cnt_q == CNT_LAST);
  assign at_setup  = (cnt_q == CNT_SETUP);

  assign scl     = scl_q;
  assign sda_out = sda_q;
  assign sda_oe  = oe_q;
  assign done    = done_q;

`ifdef OLED_I2C_ACK_CHECK_EN
  logic ack_err_q, ack_err_d;
  assign ack_err = ack_err_q;
`else
  logic unused_sda_in;
  assign unused_sda_in = sda_in;
  assign ack_err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    data_d  = data_q;
    stop_d  = stop_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
`ifdef OLED_I2C_ACK_CHECK_EN
    ack_err_d = ack_err_q;
`endif
    case (state_q)
      S_IDLE, S_HOLD: begin
        cnt_d = '0;
        sub_d = '0;
        if (accept) begin
          data_d = cmd_data;
          stop_d = cmd_stop;
`ifdef OLED_I2C_ACK_CHECK_EN
          if (cmd_start) ack_err_d = 1'b0;
`endif
          if (state_q == S_HOLD && !cmd_start) begin
            state_d = S_BIT;
            idx_d   = 3'd7;
          end else if (state_q == S_HOLD) begin
            state_d = S_RSTART;
          end else begin
            // From a released bus every byte is framed with START, even if cmd_start was low.
            state_d = S_START;
            scl_d   = 1'b1;
            sda_d   = 1'b1;
            oe_d    = 1'b1;
          end
        end
      end
      S_RSTART: begin
        if (at_setup) sda_d = 1'b1;
        if (wrap) begin
          scl_d   = 1'b1;
          state_d = S_START;
          sub_d   = 2'd0;
        end
      end
      S_START: begin
        if (wrap) begin
          if (sub_q == 2'd0) begin
            sda_d = 1'b0;
            sub_d = 2'd1;
          end else begin
            scl_d   = 1'b0;
            state_d = S_BIT;
            idx_d   = 3'd7;
            sub_d   = 2'd0;
          end
        end
      end
      S_BIT: begin
        if (sub_q == 2'd0) begin
          if (at_setup) sda_d = data_q[idx_q];
          if (wrap) begin
            scl_d = 1'b1;
            sub_d = 2'd1;
          end
        end else if (wrap) begin
          scl_d = 1'b0;
          sub_d = 2'd0;
          if (idx_q == 3'd0) state_d = S_ACK;
          else               idx_d   = idx_q - 3'd1;
        end
      end
      S_ACK: begin
        if (sub_q == 2'd0) begin
          if (at_setup) begin
            oe_d  = 1'b0;
            sda_d = 1'b1;
          end
          if (wrap) begin
            scl_d = 1'b1;
            sub_d = 2'd1;
          end
        end else begin
`ifdef OLED_I2C_ACK_CHECK_EN
          // A NACK turns this frame into a STOP frame by overriding the latched stop request.
          if (cnt_q == CNT_SAMPLE && sda_in) begin
            ack_err_d = 1'b1;
            stop_d    = 1'b1;
          end
`endif
          if (wrap) begin
            scl_d = 1'b0;
            sub_d = 2'd0;
            if (stop_q) begin
              state_d = S_STOP;
            end else begin
              state_d = S_HOLD;
              oe_d    = 1'b1;
              sda_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_STOP: begin
        if (sub_q == 2'd0) begin
          if (at_setup) begin
            oe_d  = 1'b1;
            sda_d = 1'b0;
          end
          if (wrap) begin
            scl_d = 1'b1;
            sub_d = 2'd1;
          end
        end else if (sub_q == 2'd1) begin
          if (wrap) begin
            sda_d = 1'b1;
            sub_d = 2'd2;
          end
        end else if (wrap) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
          sub_d   = 2'd0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sub_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      stop_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      stop_q  <= stop_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

`ifdef OLED_I2C_ACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) ack_err_q <= 1'b0;
    else     ack_err_q <= ack_err_d;
  end
`endif

endmodule

// File: tb/tb_oled_i2c_sequencer.sv
// Bench for oled_i2c_sequencer with HALF_PERIOD=8: a waveform model expands each command into per-cycle bus levels.
// Latency checks are pinned by literal counts measured from the pads on the first frame.
// Backpressure is exercised by presenting commands while the previous frame is still busy.
module tb_oled_i2c_sequencer;
  localparam int HP = 8;
  localparam int SS = HP / 2;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_start, cmd_stop, sda_in;
  logic [7:0] cmd_data;
  logic       cmd_ready, scl, sda_out, sda_oe, done, busy, ack_err;

  oled_i2c_sequencer #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_data(cmd_data), .sda_in(sda_in),
    .scl(scl), .sda_out(sda_out), .sda_oe(sda_oe), .done(done), .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic scl, sda, oe, done, busy, rdy, aerr;
  } smp_t;

  smp_t exp_q[$];
  smp_t e_s, a_s;
  int   tests = 0, fails = 0;
  int   acc_cnt = 0, done_cnt = 0;
  logic chk_en = 1'b0;
  logic rest_hold = 1'b0;   // bus rests in HOLD (1) or IDLE (0) once the queue drains
  logic m_aerr = 1'b0;
  logic m_sda = 1'b1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Append n cycles of constant bus levels for a busy frame.
  task automatic push(input int n, input logic s_scl, input logic s_sda, input logic s_oe);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{scl: s_scl, sda: s_sda, oe: s_oe, done: 1'b0, busy: 1'b1, rdy: 1'b0, aerr: m_aerr});
    m_sda = s_sda;
  endtask

  // Expand one accepted command into the bus waveform it must produce, starting the cycle after acceptance.
  task automatic model_cmd(input logic from_hold, input logic st, input logic sp,
                           input logic [7:0] d, input logic nack);
    if (st) m_aerr = 1'b0;
    m_sda = !from_hold;
    if (from_hold && st) begin           // repeated START: raise SDA while SCL low, then release SCL
      push(SS, 1'b0, 1'b0, 1'b1);
      push(HP - SS, 1'b0, 1'b1, 1'b1);
    end
    if (!from_hold || st) begin
      push(HP, 1'b1, 1'b1, 1'b1);
      push(HP, 1'b1, 1'b0, 1'b1);
    end
    for (int b = 7; b >= 0; b--) begin
      push(SS, 1'b0, m_sda, 1'b1);
      push(HP - SS, 1'b0, d[b], 1'b1);
      push(HP, 1'b1, d[b], 1'b1);
    end
    push(SS, 1'b0, m_sda, 1'b1);
    push(HP - SS, 1'b0, 1'b1, 1'b0);
    push(HP / 2 + 1, 1'b1, 1'b1, 1'b0);
    if (nack) m_aerr = 1'b1;
    push(HP - HP / 2 - 1, 1'b1, 1'b1, 1'b0);
    if (sp || nack) begin
      push(SS, 1'b0, 1'b1, 1'b0);
      push(HP - SS, 1'b0, 1'b0, 1'b1);
      push(HP, 1'b1, 1'b0, 1'b1);
      push(HP, 1'b1, 1'b1, 1'b1);
      rest_hold = 1'b0;
      exp_q.push_back('{scl: 1'b1, sda: 1'b1, oe: 1'b0, done: 1'b1, busy: 1'b0, rdy: 1'b1, aerr: m_aerr});
    end else begin
      rest_hold = 1'b1;
      exp_q.push_back('{scl: 1'b0, sda: 1'b0, oe: 1'b1, done: 1'b1, busy: 1'b0, rdy: 1'b1, aerr: m_aerr});
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      a_s = '{scl: scl, sda: sda_out, oe: sda_oe, done: done, busy: busy, rdy: cmd_ready, aerr: ack_err};
      if (exp_q.size() > 0) e_s = exp_q.pop_front();
      else if (rest_hold)   e_s = '{scl: 1'b0, sda: 1'b0, oe: 1'b1, done: 1'b0, busy: 1'b0, rdy: 1'b1, aerr: m_aerr};
      else                  e_s = '{scl: 1'b1, sda: 1'b1, oe: 1'b0, done: 1'b0, busy: 1'b0, rdy: 1'b1, aerr: m_aerr};
      tests++;
      if (a_s !== e_s) begin
        fails++;
        $display("FAIL cycle t=%0t {scl,sda,oe,done,busy,rdy,aerr} got %b expected %b", $time, a_s, e_s);
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;
  always @(posedge clk) if (!rst && cmd_valid && cmd_ready) acc_cnt++;

  task automatic send(input logic st, input logic sp, input logic [7:0] d, input logic keep);
    int   w;
    logic from, nk;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = st; cmd_stop = sp; cmd_data = d;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept_timeout: cmd_ready never rose for data %h", d);
      cmd_valid = 1'b0;
    end else begin
      from = rest_hold;
`ifdef OLED_I2C_ACK_CHECK_EN
      nk = sda_in;
`else
      nk = 1'b0;
`endif
      @(posedge clk);
      #1;
      if (!keep) begin
        cmd_valid = 1'b0;
        cmd_data  = ~d;   // fields must already be latched
        cmd_stop  = ~sp;
      end
      model_cmd(from, st, sp, d, nk);
    end
  endtask

  task automatic wait_done();
    int w = 0;
    while (done !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", int'(done === 1'b1), 1);
  endtask

  int k_fall, k_done, nfall, npulse, run, bad_len, acc0, done0;
  logic [7:0] bits;
  logic oe9, prev_scl;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_data = 8'h00; sda_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1);   chk("rst_sda", sda_out, 1); chk("rst_oe", sda_oe, 0);
    chk("rst_rdy", cmd_ready, 1); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_aerr", ack_err, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single framed byte 0x78 with START and STOP.
    send(1'b1, 1'b1, 8'h78, 1'b0);
    k_fall = -1; k_done = -1; nfall = 0; npulse = 0; run = 0; bad_len = 0; bits = 8'h00; oe9 = 1'b1; prev_scl = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k_fall < 0 && sda_out == 1'b0 && scl == 1'b1) k_fall = k;
      if (scl && !prev_scl) begin npulse++; run = 0; end
      if (scl && npulse > 0) begin
        run++;
        if (run == HP / 2) begin
          if (npulse <= 8) bits = {bits[6:0], sda_out};
          if (npulse == 9) oe9 = sda_oe;
        end
      end
      if (!scl && prev_scl && npulse > 0) begin
        nfall++;
        if (run != HP) bad_len++;
      end
      prev_scl = scl;
      if (done) begin k_done = k; break; end
    end
    chk("start_fall_latency", k_fall, 8);
    chk("frame_length", k_done, 8 + 8 + 9 * 16 + 8 + 8 + 8);
    chk("scl_pulses", nfall, 9);
    chk("scl_pulse_len_errs", bad_len, 0);
    chk("data_bits", int'(bits), 8'h78);
    chk("ack_slot_oe", oe9, 0);

    // Two bytes in one transaction, second presented while busy.
    send(1'b1, 1'b0, 8'h00, 1'b0);
    send(1'b0, 1'b1, 8'hAF, 1'b0);
    wait_done();

    // HOLD followed by repeated START.
    send(1'b1, 1'b0, 8'h3C, 1'b0);
    send(1'b1, 1'b1, 8'h40, 1'b0);
    wait_done();

    // NACK at the ACK slot.
    sda_in = 1'b1;
    send(1'b1, 1'b0, 8'h78, 1'b0);
    wait_done();
    sda_in = 1'b0;
    @(negedge clk);
`ifdef OLED_I2C_ACK_CHECK_EN
    chk("nack_aerr", ack_err, 1);
    chk("nack_rest_scl", scl, 1);
`else
    chk("nack_aerr", ack_err, 0);
    chk("nack_rest_scl", scl, 0);
`endif
    send(1'b1, 1'b1, 8'h00, 1'b0);
    wait_done();
    @(negedge clk);
    chk("aerr_cleared", ack_err, 0);

    // Reset in the middle of bit index 4.
    send(1'b1, 1'b1, 8'hA5, 1'b0);
    repeat (68) @(negedge clk);
    chk("bit4_scl_low", scl, 0);
    chk_en = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_scl", scl, 1); chk("midrst_oe", sda_oe, 0); chk("midrst_rdy", cmd_ready, 1);
    chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
    rst = 1'b0;
    rest_hold = 1'b0;
    m_aerr = 1'b0;
    chk_en = 1'b1;

    // Back-to-back commands with cmd_valid held.
    acc0 = acc_cnt;
    done0 = done_cnt;
    send(1'b1, 1'b1, 8'h12, 1'b1);
    send(1'b1, 1'b1, 8'h34, 1'b1);
    send(1'b1, 1'b1, 8'h56, 1'b0);
    wait_done();
    @(negedge clk);
    chk("b2b_accepts", acc_cnt - acc0, 3);
    chk("b2b_dones", done_cnt - done0, 3);

    repeat (5) @(negedge clk);
    chk("model_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
